decay_sample_gen: RTL and testbench
===================================

DECAY_SAMPLE_GEN -- requirements
Module: decay_sample_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Parameter DW, default 8: sample and init-value width.
REQ-003 Parameter CW, default 8: sample-count width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous reset, active low (0 = reset).
REQ-006 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 init_val  input  DW  first sample value; captured at accepted start.
REQ-008 shift  input  3  decay shift, captured at accepted start; 0 = constant stream.
REQ-009 count  input  CW  burst length M, captured at accepted start.
REQ-010 out_data  output  DW  current sample.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts the sample; transfer = out_valid & out_ready.
REQ-013 out_last  output  1  high with the M-th sample.
REQ-014 busy  output  1  high in SEND and DONE.
REQ-015 done  output  1  one-cycle pulse at burst end.
REQ-016 sum  output  32  running sum of transferred samples.

Function
REQ-017 FSM states SHALL be IDLE, SEND and DONE.
REQ-018 IDLE with start=1 and count>0: capture the inputs, set out_data=init_val, and enter SEND; out_valid SHALL be high on the next cycle.
REQ-019 IDLE with start=1 and count=0: enter DONE directly, with no out_valid assertion.
REQ-020 In SEND, out_valid SHALL stay 1, and out_data, out_last and the internal index SHALL stay constant until a transfer occurs.
REQ-021 Each transfer that is not the last: the next sample SHALL be cur - (cur >> shift), or cur when shift=0, in DW bits; it can never underflow.
REQ-022 The next sample SHALL appear on the cycle after the transfer; with out_ready held high, throughput SHALL be 1 sample per cycle.
REQ-023 out_last SHALL be 1 exactly when the index equals M-1.
REQ-024 A transfer with out_last=1 SHALL cause: FSM to DONE, out_valid=0 on the next cycle.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 start SHALL be ignored while busy=1; captured parameters SHALL be immune to input changes during a burst.
REQ-027 sum SHALL be cleared at each accepted start, including count=0.
REQ-028 On each transfer, sum SHALL increase by the zero-extended out_data, visible on the next cycle.
REQ-029 sum SHALL hold its value after done until the next accepted start.
REQ-030 The internal index SHALL be CW bits; M = 2^CW - 1 SHALL complete without wrap.

Reset
REQ-031 rst=0 SHALL immediately force: FSM to IDLE, out_data=0, out_valid=0, out_last=0, busy=0, done=0, sum=0, index=0, captured parameters=0, regardless of clk.
REQ-032 Reset asserted mid-burst SHALL abandon the burst, with no done pulse.
REQ-033 After rst returns to 1, the first accepted start SHALL behave exactly as from power-up.

Configuration
REQ-034 With macro DECAY_SAMPLE_GEN_SUM_EN defined, the sum accumulator SHALL be implemented per REQ-027 to REQ-029.
REQ-035 With DECAY_SAMPLE_GEN_SUM_EN undefined, sum SHALL be tied to constant 0, no accumulator register SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-036 Basic burst: init_val=128, shift=1, count=4, out_ready=1 -> samples 128, 64, 32, 16 on consecutive cycles; out_last only with 16; done pulse one cycle after the last transfer; sum=240.
REQ-037 Backpressure: same setup, out_ready=0 for 3 cycles while 64 is presented -> 64 and out_valid are held for 4 cycles; the stream then resumes with 32, 16; sum=240.
REQ-038 Zero count: count=0, start pulse -> out_valid is never asserted; done pulses on the cycle after start; sum=0.
REQ-039 Constant stream: init_val=200, shift=0, count=3 -> 200, 200, 200; sum=600 (built with DECAY_SAMPLE_GEN_SUM_EN), sum=0 (built without).
REQ-040 Reset mid-burst: rst=0 while the 2nd sample is presented -> all outputs are 0 immediately; no done pulse; after release, a new start with init_val=100, shift=2, count=2 yields 100, 75.
REQ-041 Start while busy: a start pulse with different init_val during SEND -> ignored; the burst completes with the originally captured values.

Source files
------------

// File: rtl/decay_sample_gen.sv
// Burst generator emitting a geometrically decaying sample stream with valid/ready handshake.
// Optional running sum of transferred samples enabled by macro DECAY_SAMPLE_GEN_SUM_EN.
module decay_sample_gen #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] init_val,
  input  logic [2:0]    shift,
  input  logic [CW-1:0] count,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [31:0]   sum
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state, state_nxt;
  logic [CW-1:0] idx, m_cap;
  logic [2:0]    sh_cap;
  logic [DW-1:0] cur, decayed;
  logic          accept, xfer, at_last;

  always_comb begin
    accept  = (state == IDLE) && start;
    xfer    = (state == SEND) && out_ready;
    at_last = (idx == m_cap - ONE);
    // shift of zero means a constant stream, not cur - cur
    decayed = (sh_cap == 3'd0) ? cur : cur - (cur >> sh_cap);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (count != '0) ? SEND : DONE;
      SEND: if (out_ready && at_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    out_valid = (state == SEND);
    out_last  = (state == SEND) && at_last;
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cur    <= '0;
      idx    <= '0;
      m_cap  <= '0;
      sh_cap <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cur    <= init_val;
        sh_cap <= shift;
        m_cap  <= count;
        idx    <= '0;
      end else if (xfer && !at_last) begin
        cur <= decayed;
        idx <= idx + ONE;
      end
    end
  end

  assign out_data = cur;

`ifdef DECAY_SAMPLE_GEN_SUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (xfer) begin
      sum_q <= sum_q + 32'(cur);
    end
  end

  assign sum = sum_q;
`else
  assign sum = '0;
`endif

endmodule

// File: tb/tb_decay_sample_gen.sv
// Randomized self-checking bench for decay_sample_gen against a list-based burst model.
module tb_decay_sample_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] init_val;
  logic [2:0] shift;
  logic [7:0] count;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [31:0] sum;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  decay_sample_gen #(.DW(8), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .init_val (init_val),
    .shift    (shift),
    .count    (count),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .sum      (sum)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_sum(input int unsigned acc);
`ifdef DECAY_SAMPLE_GEN_SUM_EN
    return acc;
`else
    return 32'd0;
`endif
  endfunction

  // got/exp layout: {valid, last, busy, done, data[7:0], sum[31:0]}
  function automatic logic [43:0] pack_out();
    return {out_valid, out_last, busy, done, out_data, sum};
  endfunction

  // mode 0: ready always high, 1: random ready, 2: stall 3 cycles on second sample
  task automatic run_burst(input logic [7:0] iv, input logic [2:0] sh, input logic [7:0] cnt,
                           input int mode, input bit poke);
    logic [7:0]  expq[$];
    int unsigned x, acc, k, cyc, stall, limit;
    logic [43:0] got, want;
    logic        r;
    x = iv;
    for (int unsigned i = 0; i < cnt; i++) begin
      expq.push_back(x[7:0]);
      if (sh != 3'd0) x = x - x / (32'd1 << sh);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_before_start busy got %b want 0", busy);
    end
    start = 1'b1; init_val = iv; shift = sh; count = cnt; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    init_val = 8'($urandom); shift = 3'($urandom); count = 8'($urandom);
    if (cnt == 8'd0) begin
      got = pack_out(); want = {1'b0, 1'b0, 1'b1, 1'b1, out_data, 32'd0};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL zero_count_done got %h want %h", got, want);
      end
      @(negedge clk);
      got = pack_out(); want = {1'b0, 1'b0, 1'b0, 1'b0, out_data, 32'd0};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL zero_count_idle got %h want %h", got, want);
      end
      return;
    end
    k = 0; acc = 0; cyc = 0; stall = 0; limit = 4 * cnt + 20;
    while (k < cnt && cyc < limit) begin
      got  = pack_out();
      want = {1'b1, (k == cnt - 1), 1'b1, 1'b0, expq[k], exp_sum(acc)};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL sample k=%0d got %h want %h", k, got, want);
      end
      case (mode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: begin
          if (k == 1 && stall < 3) begin r = 1'b0; stall++; end
          else r = 1'b1;
        end
      endcase
      out_ready = r;
      if (poke && cyc == 1) begin
        start = 1'b1; init_val = ~iv; shift = sh + 3'd1; count = cnt + 8'd3;
      end
      if (r) begin
        acc += 32'(expq[k]);
        k++;
      end
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    vectors++;
    if (k < cnt) begin
      miscompares++;
      $display("FAIL burst_timeout transferred %0d want %0d", k, cnt);
    end
    out_ready = 1'b0;
    got = pack_out(); want = {1'b0, 1'b0, 1'b1, 1'b1, out_data, exp_sum(acc)};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL done_pulse got %h want %h", got, want);
    end
    @(negedge clk);
    got = pack_out(); want = {1'b0, 1'b0, 1'b0, 1'b0, out_data, exp_sum(acc)};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL after_done got %h want %h", got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; init_val = '0; shift = '0; count = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (pack_out() !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_state got %h want 0", pack_out());
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_burst(8'd128, 3'd1, 8'd4, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_burst(8'd128, 3'd1, 8'd4, 2, 1'b0);
  endtask

  task automatic test_zero_count();
    run_burst(8'd77, 3'd3, 8'd0, 0, 1'b0);
  endtask

  task automatic test_constant();
    run_burst(8'd200, 3'd0, 8'd3, 1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_burst(8'd90, 3'd2, 8'd5, 0, 1'b1);
    run_burst(8'd255, 3'd1, 8'd6, 1, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    start = 1'b1; init_val = 8'd128; shift = 3'd1; count = 8'd4; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_data !== 8'd64 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_burst_second got data %0d valid %b want 64 1", out_data, out_valid);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (pack_out() !== 44'd0) begin
      miscompares++;
      $display("FAIL async_reset got %h want 0", pack_out());
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_no_done cyc=%0d got done %b busy %b want 0 0", i, done, busy);
      end
    end
    rst = 1'b1;
    run_burst(8'd100, 3'd2, 8'd2, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_burst(8'($urandom), 3'($urandom), 8'($urandom_range(0, 12)), 1, 1'($urandom));
  endtask

  task automatic test_max_count();
    run_burst(8'($urandom), 3'($urandom_range(1, 7)), 8'd255, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_constant();
    test_start_while_busy();
    test_reset_mid_burst();
    test_random();
    test_max_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
